// File: rtl/e203_ifu_prdt_pkg.sv
// Shared IFU prediction types: resolver FSM encoding, adder operand selects, ILEN constants.
package e203_ifu_prdt_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int XLEN_DEF    = 32;
  localparam int RFIDX_W_DEF = 5;

  localparam int ILEN32 = 4;
  localparam int ILEN16 = 2;

  typedef enum logic [1:0] {
    PRDT_IDLE = 2'd0,
    PRDT_REQ  = 2'd1,
    PRDT_DATA = 2'd2
  } prdt_state_e;

  typedef enum logic [1:0] {
    OPA_PC   = 2'd0,
    OPA_ZERO = 2'd1,
    OPA_X1   = 2'd2,
    OPA_RD   = 2'd3
  } opa_sel_e;

endpackage

// File: rtl/e203_ifu_prdt_add.sv
// Single next-PC adder: base (pc / 0 / x1 / port-1 data) plus imm or instruction length.
// Purely combinational; optional bit-0 clear for jalr targets.
module e203_ifu_prdt_add
  import e203_ifu_prdt_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  opa_sel_e         opa_sel,
  input  logic [PC_W-1:0]  pc,
  input  logic [XLEN-1:0]  rf_x1,
  input  logic [XLEN-1:0]  rd_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             use_ilen,
  input  logic             rv32,
  input  logic             clr_lsb,
  output logic [PC_W-1:0]  sum
);

  logic [PC_W-1:0] opa;
  logic [PC_W-1:0] opb;

  always_comb begin
    case (opa_sel)
      OPA_PC:   opa = pc;
      OPA_ZERO: opa = '0;
      OPA_X1:   opa = rf_x1[PC_W-1:0];
      default:  opa = rd_data[PC_W-1:0];
    endcase
    opb = use_ilen ? (rv32 ? PC_W'(ILEN32) : PC_W'(ILEN16)) : imm[PC_W-1:0];
    sum = opa + opb;
    if (clr_lsb) begin
      sum[0] = 1'b0;
    end
  end

endmodule

// File: rtl/e203_ifu_prdt.sv
// Static branch prediction / next-PC for the IR instruction; 0 cycles except jalr xN (>=2).
// Holds bpu_wait while x1 is busy or while jalr xN arbitrates for register-file port 1.
module e203_ifu_prdt
  import e203_ifu_prdt_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int RFIDX_W = RFIDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ir_valid,
  input  logic [PC_W-1:0]    pc,
  input  logic               dec_rv32,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
  input  logic               x1_busy,
  input  logic               xn_busy,
  input  logic [XLEN-1:0]    rf_x1,
  output logic               rd_req,
  input  logic               rd_gnt,
  input  logic [XLEN-1:0]    rd_data,
  input  logic               flush,
  output logic               prdt_valid,
  output logic               prdt_taken,
  output logic [PC_W-1:0]    prdt_pc,
  output logic               bpu_wait
);

  prdt_state_e     state;
  prdt_state_e     state_nxt;
  opa_sel_e        opa_sel;
  logic            use_ilen;
  logic            clr_lsb;
  logic            is_x0;
  logic            is_x1;
  logic [PC_W-1:0] add_sum;

  assign is_x0 = (dec_jalr_rs1idx == RFIDX_W'(0));
  assign is_x1 = (dec_jalr_rs1idx == RFIDX_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRDT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = PRDT_IDLE;
    opa_sel    = OPA_PC;
    use_ilen   = 1'b1;
    clr_lsb    = 1'b0;
    prdt_valid = 1'b0;
    prdt_taken = 1'b0;
    bpu_wait   = 1'b0;
    rd_req     = 1'b0;
    if (!rst && ir_valid) begin
      prdt_valid = 1'b1;
      if (dec_jal) begin
        prdt_taken = 1'b1;
        use_ilen   = 1'b0;
      end else if (dec_bxx) begin
        // backward branches predicted taken
        prdt_taken = dec_bjp_imm[XLEN-1];
        use_ilen   = !dec_bjp_imm[XLEN-1];
      end else if (dec_jalr) begin
        prdt_taken = 1'b1;
        use_ilen   = 1'b0;
        clr_lsb    = 1'b1;
        if (is_x0) begin
          opa_sel = OPA_ZERO;
        end else if (is_x1) begin
          opa_sel = OPA_X1;
          if (x1_busy) begin
            prdt_valid = 1'b0;
            prdt_taken = 1'b0;
            bpu_wait   = 1'b1;
          end
        end else begin
          opa_sel = OPA_RD;
          case (state)
            PRDT_IDLE: begin
              prdt_valid = 1'b0;
              prdt_taken = 1'b0;
              bpu_wait   = 1'b1;
              state_nxt  = PRDT_REQ;
            end
            PRDT_REQ: begin
              prdt_valid = 1'b0;
              prdt_taken = 1'b0;
              bpu_wait   = 1'b1;
              rd_req     = !xn_busy;
              state_nxt  = (!xn_busy && rd_gnt) ? PRDT_DATA : PRDT_REQ;
            end
            default: state_nxt = PRDT_IDLE;
          endcase
        end
      end
      // flush overrides any grant or completion in the same cycle
      if (flush) begin
        prdt_valid = 1'b0;
        rd_req     = 1'b0;
        state_nxt  = PRDT_IDLE;
      end
    end
  end

  e203_ifu_prdt_add #(
    .PC_W (PC_W),
    .XLEN (XLEN)
  ) u_add (
    .opa_sel  (opa_sel),
    .pc       (pc),
    .rf_x1    (rf_x1),
    .rd_data  (rd_data),
    .imm      (dec_bjp_imm),
    .use_ilen (use_ilen),
    .rv32     (dec_rv32),
    .clr_lsb  (clr_lsb),
    .sum      (add_sum)
  );

  assign prdt_pc = (!rst && ir_valid) ? add_sum : '0;

endmodule

// File: tb/tb_e203_ifu_prdt.sv
// Bench for e203_ifu_prdt: directed scenarios with literal expectations, then random traffic
// compared every cycle against a rule-level prediction model.
module tb_e203_ifu_prdt;

  localparam int PC_W    = 32;
  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               ir_valid;
  logic [PC_W-1:0]    pc;
  logic               dec_rv32;
  logic               dec_jal;
  logic               dec_jalr;
  logic               dec_bxx;
  logic [XLEN-1:0]    dec_bjp_imm;
  logic [RFIDX_W-1:0] dec_jalr_rs1idx;
  logic               x1_busy;
  logic               xn_busy;
  logic [XLEN-1:0]    rf_x1;
  logic               rd_req;
  logic               rd_gnt;
  logic [XLEN-1:0]    rd_data;
  logic               flush;
  logic               prdt_valid;
  logic               prdt_taken;
  logic [PC_W-1:0]    prdt_pc;
  logic               bpu_wait;

  int errors = 0;
  int checks = 0;

  // model memory: a jalr xN resolution has begun / port 1 was granted last cycle
  logic m_pend = 1'b0;
  logic m_gnt  = 1'b0;
  logic m_wait = 1'b0;

  always #5 clk = ~clk;

  e203_ifu_prdt #(
    .PC_W    (PC_W),
    .XLEN    (XLEN),
    .RFIDX_W (RFIDX_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ir_valid        (ir_valid),
    .pc              (pc),
    .dec_rv32        (dec_rv32),
    .dec_jal         (dec_jal),
    .dec_jalr        (dec_jalr),
    .dec_bxx         (dec_bxx),
    .dec_bjp_imm     (dec_bjp_imm),
    .dec_jalr_rs1idx (dec_jalr_rs1idx),
    .x1_busy         (x1_busy),
    .xn_busy         (xn_busy),
    .rf_x1           (rf_x1),
    .rd_req          (rd_req),
    .rd_gnt          (rd_gnt),
    .rd_data         (rd_data),
    .flush           (flush),
    .prdt_valid      (prdt_valid),
    .prdt_taken      (prdt_taken),
    .prdt_pc         (prdt_pc),
    .bpu_wait        (bpu_wait)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : model_cmp
    logic [31:0] seq;
    logic [31:0] e_pc;
    logic        e_v, e_t, e_w, e_r, n_pend, n_gnt, quiet;
    e_v = 0; e_t = 0; e_w = 0; e_r = 0; e_pc = 0; n_pend = 0; n_gnt = 0;
    quiet = rst || !ir_valid;
    if (!quiet) begin
      seq  = pc + (dec_rv32 ? 32'd4 : 32'd2);
      e_v  = 1;
      e_pc = seq;
      if (dec_jal) begin
        e_t = 1; e_pc = pc + dec_bjp_imm;
      end else if (dec_bxx) begin
        e_t  = dec_bjp_imm[31];
        e_pc = e_t ? pc + dec_bjp_imm : seq;
      end else if (dec_jalr) begin
        if (dec_jalr_rs1idx == 0) begin
          e_t = 1; e_pc = dec_bjp_imm & ~32'd1;
        end else if (dec_jalr_rs1idx == 1) begin
          if (x1_busy) begin
            e_v = 0; e_w = 1;
          end else begin
            e_t = 1; e_pc = (rf_x1 + dec_bjp_imm) & ~32'd1;
          end
        end else if (m_gnt) begin
          e_t = 1; e_pc = (rd_data + dec_bjp_imm) & ~32'd1;
        end else begin
          e_v = 0; e_w = 1;
          if (m_pend) begin
            e_r = !xn_busy;
            if (e_r && rd_gnt) n_gnt = 1;
            else n_pend = 1;
          end else begin
            n_pend = 1;
          end
        end
      end
      if (flush) begin
        e_v = 0; e_r = 0; n_pend = 0; n_gnt = 0;
      end
    end
    chk("prdt_valid", prdt_valid, e_v);
    chk("bpu_wait", bpu_wait, e_w);
    chk("rd_req", rd_req, e_r);
    if (e_v || quiet) begin
      chk("prdt_taken", prdt_taken, e_t);
      chk("prdt_pc", prdt_pc, e_pc);
    end
    m_pend = n_pend;
    m_gnt  = n_gnt;
    m_wait = e_w;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [31:0] p, input logic r32, input int kind,
                       input logic [31:0] imm, input logic [4:0] rs);
    ir_valid        = 1;
    pc              = p;
    dec_rv32        = r32;
    dec_jal         = (kind == 1);
    dec_bxx         = (kind == 2);
    dec_jalr        = (kind == 3);
    dec_bjp_imm     = imm;
    dec_jalr_rs1idx = rs;
  endtask

  initial begin
    rst = 1; ir_valid = 0; pc = 0; dec_rv32 = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    dec_bjp_imm = 0; dec_jalr_rs1idx = 0; x1_busy = 0; xn_busy = 0; rf_x1 = 0;
    rd_gnt = 0; rd_data = 0; flush = 0;
    step();
    step();
    @(negedge clk);
    chk("rst_valid", prdt_valid, 0);
    chk("rst_taken", prdt_taken, 0);
    chk("rst_pc", prdt_pc, 0);
    chk("rst_wait", bpu_wait, 0);
    chk("rst_req", rd_req, 0);
    step(); rst = 0;

    instr(32'h1000, 1, 0, 0, 0);
    @(negedge clk);
    chk("nb_valid", prdt_valid, 1); chk("nb_taken", prdt_taken, 0); chk("nb_pc", prdt_pc, 32'h1004);
    step(); instr(32'h1000, 1, 1, 32'h20, 0);
    @(negedge clk);
    chk("jal_taken", prdt_taken, 1); chk("jal_pc", prdt_pc, 32'h1020);
    step(); instr(32'h2000, 1, 2, 32'hFFFF_FFF0, 0);
    @(negedge clk);
    chk("bxx_bwd_taken", prdt_taken, 1); chk("bxx_bwd_pc", prdt_pc, 32'h1FF0);
    step(); instr(32'h2000, 0, 2, 32'h10, 0);
    @(negedge clk);
    chk("bxx_fwd_taken", prdt_taken, 0); chk("bxx_fwd_pc", prdt_pc, 32'h2002);

    step(); instr(32'h3000, 1, 3, 32'h4, 1); rf_x1 = 32'h3001; x1_busy = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("x1_wait", bpu_wait, 1); chk("x1_wait_valid", prdt_valid, 0);
      step();
    end
    x1_busy = 0;
    @(negedge clk);
    chk("x1_valid", prdt_valid, 1); chk("x1_pc", prdt_pc, 32'h3004); chk("x1_nowait", bpu_wait, 0);

    step(); instr(32'h5000, 1, 3, 32'h11, 5); rd_data = 32'h4000;
    @(negedge clk);
    chk("xn_idle_wait", bpu_wait, 1); chk("xn_idle_req", rd_req, 0);
    step(); xn_busy = 1;
    @(negedge clk);
    chk("xn_busy_req", rd_req, 0); chk("xn_busy_wait", bpu_wait, 1);
    step(); xn_busy = 0;
    @(negedge clk); chk("xn_nognt1_req", rd_req, 1);
    step();
    @(negedge clk); chk("xn_nognt2_req", rd_req, 1);
    step(); rd_gnt = 1;
    @(negedge clk); chk("xn_gnt_req", rd_req, 1);
    step(); rd_gnt = 0;
    @(negedge clk);
    chk("xn_valid", prdt_valid, 1); chk("xn_taken", prdt_taken, 1);
    chk("xn_pc", prdt_pc, 32'h4010); chk("xn_data_wait", bpu_wait, 0);

    step(); ir_valid = 0;
    step(); instr(32'h6000, 1, 3, 32'h11, 7); rd_gnt = 1;
    step();
    @(negedge clk); chk("fl_req", rd_req, 1);
    step(); flush = 1;
    @(negedge clk); chk("fl_data_valid", prdt_valid, 0);
    step(); flush = 0;
    @(negedge clk);
    chk("fl_next_valid", prdt_valid, 0); chk("fl_next_req", rd_req, 0); chk("fl_next_wait", bpu_wait, 1);
    step(); ir_valid = 0; rd_gnt = 0;

    step(); instr(32'h7000, 1, 3, 32'h11, 9);
    step(); rst = 1;
    @(negedge clk); chk("rq_rst_req", rd_req, 0);
    step(); rst = 0; ir_valid = 0;
    @(negedge clk);
    chk("rq_after_valid", prdt_valid, 0); chk("rq_after_wait", bpu_wait, 0);
    chk("rq_after_req", rd_req, 0); chk("rq_after_pc", prdt_pc, 0);
    step(); ir_valid = 1; rd_gnt = 1;
    @(negedge clk); chk("rq_idle_req", rd_req, 0); chk("rq_idle_wait", bpu_wait, 1);
    step(); ir_valid = 0; rd_gnt = 0;

    step(); instr(32'hFFFF_FFFC, 1, 1, 32'h8, 0);
    @(negedge clk); chk("wrap_taken", prdt_taken, 1); chk("wrap_pc", prdt_pc, 32'h4);
    step(); ir_valid = 0; dec_jal = 0;

    for (int i = 0; i < 4000; i++) begin
      logic hold;
      int   kind;
      int   r;
      step();
      hold = m_wait && !flush;
      if (!hold) begin
        kind = int'($urandom_range(0, 4));
        instr($urandom, 1'($urandom_range(0, 1)), (kind > 3) ? 3 : kind, $urandom, 5'd0);
        r = int'($urandom_range(0, 3));
        dec_jalr_rs1idx = (r == 0) ? 5'd0 : (r == 1) ? 5'd1 : 5'($urandom_range(2, 31));
        ir_valid = ($urandom_range(0, 7) != 0);
      end
      x1_busy = ($urandom_range(0, 2) == 0);
      xn_busy = ($urandom_range(0, 2) == 0);
      rd_gnt  = 1'($urandom_range(0, 1));
      rd_data = $urandom;
      rf_x1   = $urandom;
      flush   = ($urandom_range(0, 19) == 0);
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e203_ifu_prdt.md
# e203_ifu_prdt

Static branch-prediction and next-PC target stage in the IFU, directly downstream of the IFU mini-decoder. It consumes the decoder's branch/jump classification (`jal`/`jalr`/`bxx`, immediate, `jalr` rs1 index) for the instruction held in the IR and produces a taken/not-taken prediction and a target PC. `jalr` through a general register is resolved by a small FSM that arbitrates for register-file read port 1. `jalr` through x1 waits on the x1 dependency.

## Interface
Parameters:
- `PC_W`, 32, PC width
- `XLEN`, 32, data/immediate width
- `RFIDX_W`, 5, register index width

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ir_valid`  in  1  IR holds a valid instruction this cycle
- `pc`  in  PC_W  PC of the IR instruction
- `dec_rv32`  in  1  1 = 32-bit instruction, 0 = 16-bit
- `dec_jal`, `dec_jalr`, `dec_bxx`  in  1 each  decoder classification; at most one set
- `dec_bjp_imm`  in  XLEN  sign-extended branch/jump immediate
- `dec_jalr_rs1idx`  in  RFIDX_W  `jalr` base register index
- `x1_busy`  in  1  x1 has an outstanding write (OITF or EXU)
- `xn_busy`  in  1  register `dec_jalr_rs1idx` has an outstanding write
- `rf_x1`  in  XLEN  current x1 value (dedicated read)
- `rd_req`  out  1  request for register-file read port 1
- `rd_gnt`  in  1  port 1 granted this cycle
- `rd_data`  in  XLEN  port-1 data, valid the cycle after the grant
- `flush`  in  1  pipeline flush; cancels any pending resolution
- `prdt_valid`  out  1  prediction valid this cycle
- `prdt_taken`  out  1  predicted taken
- `prdt_pc`  out  PC_W  predicted next PC
- `bpu_wait`  out  1  IR must hold; prediction not yet available

## Operation
- **Non-branch instruction** (`ir_valid` set, no `dec_*` bit set): `prdt_valid`=1, `prdt_taken`=0, `prdt_pc`=pc+(dec_rv32?4:2).
- **`jal`:** taken, target pc+imm, same cycle.
- **`bxx`:** taken iff imm[XLEN-1]=1 (backward). Taken target is pc+imm; not-taken target is pc+4 or pc+2.
- **`jalr` x0:** taken, target imm with bit0 cleared, same cycle.
- **`jalr` x1:**
  - If `x1_busy` is clear: taken, target (rf_x1+imm)&~1, same cycle.
  - If `x1_busy` is set: `bpu_wait`=1, `prdt_valid`=0. This wait is combinational; no state change.
- **`jalr` xN (N≥2):** FSM with states IDLE, REQ, DATA.
  - **IDLE:** on `ir_valid`&`dec_jalr`&xN, go to REQ. `bpu_wait`=1.
  - **REQ:** `rd_req`=!xn_busy and `bpu_wait`=1. If `rd_req`&`rd_gnt`, go to DATA.
  - **DATA:** `rd_data` is captured combinationally. `prdt_valid`=1, taken, target (rd_data+imm)&~1, `bpu_wait`=0. Go to IDLE.
- **IR handshake:** upstream advances the IR on every cycle with `prdt_valid`=1. IR contents must stay stable while `bpu_wait`=1.
- **`flush`:** forces IDLE next cycle and masks `prdt_valid` and `rd_req` this cycle. It wins over a simultaneous `rd_gnt` or DATA completion.
- **Idle outputs:** when `ir_valid`=0, all outputs are 0 and the FSM stays or returns to IDLE.
- **Arithmetic:** all additions are modulo 2^PC_W and wrap silently; imm is truncated to PC_W.

## Timing
- Reset: FSM is IDLE. `prdt_valid`, `prdt_taken`, `prdt_pc`, `bpu_wait` and `rd_req` are all 0.
- Latency:
  - 0 cycles for non-branch, `jal`, `bxx`, `jalr` x0, and `jalr` x1 when not busy.
  - `jalr` xN: minimum 2 cycles. The IDLE→REQ decision is made in the first cycle (`rd_req` already asserted combinationally in REQ), and the result appears in the DATA cycle.
- Every busy or no-grant cycle in REQ adds one cycle. `rd_req` is held until granted.
- `rst` in REQ or DATA: IDLE next cycle, no `prdt_valid`.
- Outputs are combinational from the FSM state and inputs. The only registers are the FSM state.

## Structure
- FSM state encoding (2 bits), ILEN constants (4/2) and the parameter defaults belong in the shared IFU defines/package.
- One sub-module, `e203_ifu_prdt_add`: a single PC_W adder with operand muxes (pc / 0 / rf_x1 / rd_data; imm / ilen) and the optional bit-0 clear. It is instantiated once, so only one adder is used.

## Test plan
- **Non-branch and `jal`:**
  - pc=0x1000, rv32, no `dec_*` set → same cycle: `prdt_valid`=1, `prdt_taken`=0, `prdt_pc`=0x1004.
  - `jal` with imm=0x20 → `prdt_pc`=0x1020, taken.
- **`bxx` direction:**
  - pc=0x2000, imm=0xFFFFFFF0 → taken, 0x1FF0.
  - imm=0x10, rv16 → not taken, 0x2002.
- **`jalr` x1 dependency:** `x1_busy`=1 for 3 cycles, rf_x1=0x3001, imm=4 → `bpu_wait`=1 for 3 cycles, then `prdt_pc`=0x3004 the cycle `x1_busy` drops.
- **`jalr` x5 with arbitration:** `xn_busy`=1 for 1 cycle, `rd_gnt` delayed 2 cycles, rd_data=0x4000, imm=0x11 → `rd_req` held until granted; next cycle `prdt_valid`=1, target 0x4010.
- **Flush:** `flush` in the DATA cycle → no `prdt_valid`, FSM IDLE next cycle. `rst` asserted in REQ → all outputs 0 next cycle.
- **Wrap:** pc=0xFFFFFFFC, `jal` imm=8 → `prdt_pc`=0x00000004.
